// File: rtl/upbus_pkg.sv
// Shared definitions for the microprocessor register bus initiator:
// FSM state encoding and the width of the read-wait counter.
package upbus_pkg;

    // Host transaction FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Width of the read-wait counter; holds RD_WAIT-1 for RD_WAIT in 0..7.
    localparam int CNT_W = 3;

endpackage

// File: rtl/upbus_rdor.sv
// Read-data collector for the register bus. Every slave gates its read bus
// with its own enable, so OR-ing all slices yields the selected slave's data.
module upbus_rdor
    import upbus_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int NREG   = 16
) (
    input  logic [NREG*DWIDTH-1:0] updo_bus,
    output logic [DWIDTH-1:0]      rd_data
);

    // OR-reduce all slave slices down to one data word.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch or
        // loop touches it, so no path leaves it unassigned and no latch appears.
        rd_data = '0;
        for (int i = 0; i < NREG; i++) begin
            rd_data = rd_data | updo_bus[i*DWIDTH +: DWIDTH];
        end
    end

endmodule

// File: rtl/upbus_master.sv
// Initiator side of the on-chip microprocessor register bus.
// Accepts single host read/write requests, decodes the address into one-hot
// slave enables, strobes writes and collects gated read data.
// Optional sticky parity-error status is built when UPBUS_PARCHK_EN is defined;
// without it par_sts/par_irq are tied low and the parity inputs are ignored.
module upbus_master
    import upbus_pkg::*;
#(
    parameter int DWIDTH  = 8,
    parameter int AWIDTH  = 4,
    parameter int NREG    = 16,
    parameter int RD_WAIT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hreq,
    input  logic                   hwr,
    input  logic [AWIDTH-1:0]      haddr,
    input  logic [DWIDTH-1:0]      hwdata,
    output logic                   hack,
    output logic                   herr,
    output logic [DWIDTH-1:0]      hrdata,
    output logic                   hbusy,
    output logic [NREG-1:0]        upen,
    output logic                   upws,
    output logic [DWIDTH-1:0]      updi,
    input  logic [NREG*DWIDTH-1:0] updo_bus,
    input  logic [NREG-1:0]        par_err_vec,
    input  logic                   par_clr,
    output logic [NREG-1:0]        par_sts,
    output logic                   par_irq
);

    state_t             state;
    state_t             state_nxt;

    // Request captured in IDLE and held for the rest of the transaction.
    logic [AWIDTH-1:0]  addr_q;
    logic               wr_q;
    logic [DWIDTH-1:0]  wdata_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;

    // Control strobes from the next-state logic to the datapath registers.
    logic               cap_req;
    logic               cap_rd;
    logic               cnt_load;
    logic               cnt_dec;

    logic               in_range;
    logic [NREG-1:0]    dec;
    logic [DWIDTH-1:0]  rd_or;

    // Zero-extend by one bit so NREG == 2**AWIDTH still compares correctly.
    assign in_range = ({1'b0, haddr} < (AWIDTH + 1)'(NREG));

    upbus_rdor #(
        .DWIDTH (DWIDTH),
        .NREG   (NREG)
    ) u_rdor (
        .updo_bus (updo_bus),
        .rd_data  (rd_or)
    );

    // One-hot decode of the captured register index.
    always_comb begin
        dec = '0;
        for (int i = 0; i < NREG; i++) begin
            dec[i] = (addr_q == AWIDTH'(i));
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here; it only takes effect on a clock edge,
        // so a transaction aborted by rst still gets one clean cycle boundary.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of process order.
            state <= state_nxt;
        end
    end

    // Next-state logic and bus outputs, all decoded from the current state.
    always_comb begin
        state_nxt = state;
        cap_req   = 1'b0;
        cap_rd    = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        hack      = 1'b0;
        herr      = 1'b0;
        hbusy     = 1'b1;
        upen      = '0;
        upws      = 1'b0;
        updi      = '0;

        case (state)
            ST_IDLE: begin
                hbusy = 1'b0;
                if (hreq) begin
                    cap_req   = 1'b1;
                    state_nxt = in_range ? ST_ACC : ST_DONE;
                end
            end

            ST_ACC: begin
                upen = dec;
                updi = wdata_q;
                if (wr_q) begin
                    upws      = 1'b1;
                    state_nxt = ST_DONE;
                end else if (RD_WAIT == 0) begin
                    cap_rd    = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    cnt_load  = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end

            ST_WAIT: begin
                upen = dec;
                updi = wdata_q;
                if (cnt_q == '0) begin
                    cap_rd    = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            ST_DONE: begin
                hack      = 1'b1;
                herr      = err_q;
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request capture and read-wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (cap_req) begin
                addr_q  <= haddr;
                wr_q    <= hwr;
                wdata_q <= hwdata;
                err_q   <= ~in_range;
            end
            if (cnt_load) begin
                cnt_q <= CNT_W'(RD_WAIT - 1);
            end else if (cnt_dec) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Host read data, updated only when a read completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            hrdata <= '0;
        end else if (cap_rd) begin
            hrdata <= rd_or;
        end
    end

`ifdef UPBUS_PARCHK_EN
    // Sticky per-slave parity status; a new error wins over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_sts <= '0;
            par_irq <= 1'b0;
        end else begin
            par_sts <= (par_sts & ~{NREG{par_clr}}) | par_err_vec;
            par_irq <= |par_sts;
        end
    end
`else
    logic unused_par;

    assign par_sts    = '0;
    assign par_irq    = 1'b0;
    assign unused_par = ^{par_err_vec, par_clr};
`endif

endmodule

// File: tb/tb_upbus_master.sv
// Directed testbench for upbus_master: default-parameter instance for the main
// traffic and a NREG=12 instance for out-of-range decoding.
`timescale 1ns/1ps
module tb_upbus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         hreq, hwr;
    logic [3:0]   haddr;
    logic [7:0]   hwdata;
    logic         hack, herr, hbusy, upws;
    logic [7:0]   hrdata, updi;
    logic [15:0]  upen;
    logic [127:0] updo_bus;
    logic [15:0]  par_err_vec, par_sts;
    logic         par_clr, par_irq;

    logic         hreq2;
    logic [3:0]   haddr2;
    logic         hack2, herr2, hbusy2, upws2, par_irq2;
    logic [7:0]   hrdata2, updi2;
    logic [11:0]  upen2, par_sts2, par_err_vec2;
    logic [95:0]  updo_bus2;

    logic [7:0]   mem [16];
    int           hack_cnt = 0;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef UPBUS_PARCHK_EN
    localparam logic PAR_ON = 1'b1;
`else
    localparam logic PAR_ON = 1'b0;
`endif

    upbus_master u_dut (
        .clk (clk), .rst (rst), .hreq (hreq), .hwr (hwr), .haddr (haddr),
        .hwdata (hwdata), .hack (hack), .herr (herr), .hrdata (hrdata),
        .hbusy (hbusy), .upen (upen), .upws (upws), .updi (updi),
        .updo_bus (updo_bus), .par_err_vec (par_err_vec), .par_clr (par_clr),
        .par_sts (par_sts), .par_irq (par_irq)
    );

    upbus_master #(.NREG(12)) u_dut12 (
        .clk (clk), .rst (rst), .hreq (hreq2), .hwr (1'b0), .haddr (haddr2),
        .hwdata (8'h00), .hack (hack2), .herr (herr2), .hrdata (hrdata2),
        .hbusy (hbusy2), .upen (upen2), .upws (upws2), .updi (updi2),
        .updo_bus (updo_bus2), .par_err_vec (par_err_vec2), .par_clr (1'b0),
        .par_sts (par_sts2), .par_irq (par_irq2)
    );

    assign par_err_vec2 = '0;

    // Slave models: registers gated onto the read bus by their enable.
    always_comb begin
        updo_bus = '0;
        for (int i = 0; i < 16; i++) updo_bus[i*8 +: 8] = upen[i] ? mem[i] : 8'h00;
    end

    always_comb begin
        updo_bus2 = '0;
        for (int i = 0; i < 12; i++) updo_bus2[i*8 +: 8] = upen2[i] ? mem[i] : 8'h00;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(i);
            mem[1]  <= 8'h96;
            mem[3]  <= 8'h5C;
            mem[5]  <= 8'h71;
            mem[7]  <= 8'h3E;
            mem[15] <= 8'hE1;
        end else begin
            for (int i = 0; i < 16; i++) if (upen[i] && upws) mem[i] <= updi;
        end
    end

    always @(negedge clk) if (hack === 1'b1) hack_cnt <= hack_cnt + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One host transaction on the main instance, bounded wait for hack.
    task automatic host_txn(input logic wr, input logic [3:0] a, input logic [7:0] d,
                            output logic [7:0] rd, output logic err);
        int n = 0;
        hreq = 1'b1; hwr = wr; haddr = a; hwdata = d;
        tick();
        hreq = 1'b0;
        while (hack !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("txn_hack_seen", hack, 1'b1);
        rd  = hrdata;
        err = herr;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic       err;
        int         hc0;

        rst = 1'b1; hreq = 1'b0; hwr = 1'b0; haddr = '0; hwdata = '0;
        par_err_vec = '0; par_clr = 1'b0; hreq2 = 1'b0; haddr2 = '0;
        repeat (3) tick();

        check("reset_outputs", {hack, herr, hrdata, hbusy, upen, upws, updi, par_sts, par_irq}, '0);
        check("reset_outputs12", {hack2, herr2, hrdata2, hbusy2, upen2, upws2, updi2}, '0);
        rst = 1'b0;
        tick();

        // Read slave 3 with RD_WAIT=1: enable held T+1..T+2, hack at T+3.
        hreq = 1'b1; hwr = 1'b0; haddr = 4'd3;
        tick();
        hreq = 1'b0; haddr = '0;
        check("rd_t1_upen", upen, 16'h0008);
        check("rd_t1_ctl", {upws, hack, hbusy}, 3'b001);
        tick();
        check("rd_t2_upen", upen, 16'h0008);
        check("rd_t2_hack", hack, 1'b0);
        tick();
        check("rd_t3_ack", {hack, herr, upen}, {1'b1, 1'b0, 16'h0000});
        check("rd_t3_data", hrdata, 8'h5C);
        tick();
        check("rd_t4_idle", {hack, hbusy}, 2'b00);

        // Write A5 to slave 3: strobe only in T+1, hack in T+2.
        hreq = 1'b1; hwr = 1'b1; haddr = 4'd3; hwdata = 8'hA5;
        tick();
        hreq = 1'b0; hwdata = '0;
        check("wr_t1_bus", {upen, upws, updi, hack}, {16'h0008, 1'b1, 8'hA5, 1'b0});
        tick();
        check("wr_t2_ack", {hack, herr, upen, upws, updi}, {1'b1, 1'b0, 16'h0000, 1'b0, 8'h00});
        check("wr_committed", mem[3], 8'hA5);
        tick();
        check("wr_t3_idle", hbusy, 1'b0);
        host_txn(1'b0, 4'd3, 8'h00, rd, err);
        check("wr_readback", {err, rd}, {1'b0, 8'hA5});

        // Highest in-range index.
        host_txn(1'b0, 4'd15, 8'h00, rd, err);
        check("rd_top_index", {err, rd}, {1'b0, 8'hE1});

        // Request while busy is dropped: only the read of slave 7 completes.
        hc0 = hack_cnt;
        hreq = 1'b1; hwr = 1'b0; haddr = 4'd7;
        tick();
        hwr = 1'b1; haddr = 4'd2; hwdata = 8'hFF;
        tick();
        hreq = 1'b0;
        repeat (6) tick();
        check("busy_one_hack", hack_cnt - hc0, 1);
        check("busy_rdata", hrdata, 8'h3E);
        check("busy_no_write", mem[2], 8'h02);

        // Reset during WAIT aborts with no hack.
        hc0 = hack_cnt;
        hreq = 1'b1; hwr = 1'b0; haddr = 4'd3;
        tick();
        hreq = 1'b0;
        tick();
        check("abort_in_wait", {upen, hbusy}, {16'h0008, 1'b1});
        rst = 1'b1;
        tick();
        check("abort_outputs", {hack, herr, hrdata, hbusy, upen, upws, updi, par_sts, par_irq}, '0);
        rst = 1'b0;
        repeat (3) tick();
        check("abort_no_hack", hack_cnt - hc0, 0);
        host_txn(1'b0, 4'd5, 8'h00, rd, err);
        check("abort_then_read", {err, rd}, {1'b0, 8'h71});

        // NREG=12 instance: valid read, then out-of-range indices 13 and 12.
        hreq2 = 1'b1; haddr2 = 4'd1;
        tick();
        hreq2 = 1'b0;
        tick();
        tick();
        check("r12_read", {hack2, herr2, hrdata2}, {1'b1, 1'b0, 8'h96});
        tick();
        hreq2 = 1'b1; haddr2 = 4'd13;
        tick();
        hreq2 = 1'b0;
        check("oor13_ack", {hack2, herr2, hbusy2, upen2, upws2}, {3'b111, 12'h000, 1'b0});
        check("oor13_hold", hrdata2, 8'h96);
        tick();
        check("oor13_after", {hack2, hbusy2, upen2}, {2'b00, 12'h000});
        hreq2 = 1'b1; haddr2 = 4'd12;
        tick();
        hreq2 = 1'b0;
        check("oor12_ack", {hack2, herr2, upen2, hrdata2}, {2'b11, 12'h000, 8'h96});
        tick();

        // Sticky parity status and interrupt.
        par_err_vec = 16'h0020;
        tick();
        par_err_vec = '0;
        check("par_set", {par_sts, par_irq}, {(PAR_ON ? 16'h0020 : 16'h0000), 1'b0});
        tick();
        check("par_irq", {par_sts, par_irq}, {(PAR_ON ? 16'h0020 : 16'h0000), PAR_ON});
        par_clr = 1'b1; par_err_vec = 16'h0020;
        tick();
        par_err_vec = '0;
        check("par_set_wins", par_sts, PAR_ON ? 16'h0020 : 16'h0000);
        tick();
        par_clr = 1'b0;
        check("par_clear", par_sts, 16'h0000);
        tick();
        check("par_irq_clear", par_irq, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
